// File: rtl/neander_pkg.sv
// Shared definitions for the Neander control unit: opcodes, ALU select codes,
// sequencer state encoding and the jump-condition helper.
package neander_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 8;

    // Opcodes live in the upper nibble of the instruction byte
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU select codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_NOT  = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_OPER   = 4'd2,
        ST_OPER_W = 4'd3,
        ST_DATA   = 4'd4,
        ST_LDRDM  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_STORE  = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    // Branch decision from the stored flags {N,Z}; non-jump opcodes never take
    function automatic logic jump_taken(input logic [3:0] op, input logic [1:0] nz);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JN:   taken = nz[1];
            OP_JZ:   taken = nz[0];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/neander_decode.sv
// Combinational opcode classifier: tells the sequencer which path an
// instruction takes and which ALU operation it needs.
module neander_decode
    import neander_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_jump,
    output logic       is_alu,
    output logic       needs_operand,
    output logic       is_store,
    output logic       is_halt,
    output logic [2:0] alu_sel
);

    // Opcode classification; unlisted opcodes fall through as NOP
    always_comb begin
        is_jump       = 1'b0;
        is_alu        = 1'b0;
        needs_operand = 1'b0;
        is_store      = 1'b0;
        is_halt       = 1'b0;
        alu_sel       = ALU_PASS;
        case (opcode)
            OP_STA: begin
                needs_operand = 1'b1;
                is_store      = 1'b1;
            end
            OP_LDA: begin
                needs_operand = 1'b1;
                is_alu        = 1'b1;
            end
            OP_ADD: begin
                needs_operand = 1'b1;
                is_alu        = 1'b1;
                alu_sel       = ALU_ADD;
            end
            OP_OR: begin
                needs_operand = 1'b1;
                is_alu        = 1'b1;
                alu_sel       = ALU_OR;
            end
            OP_AND: begin
                needs_operand = 1'b1;
                is_alu        = 1'b1;
                alu_sel       = ALU_AND;
            end
            OP_NOT: begin
                is_alu        = 1'b1;
                alu_sel       = ALU_NOT;
            end
            OP_JMP, OP_JN, OP_JZ: begin
                needs_operand = 1'b1;
                is_jump       = 1'b1;
            end
            OP_HLT: begin
                is_halt       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/neander_control.sv
// Neander sequencer and register file. Walks fetch/decode/execute against a
// synchronous RAM (data one cycle after address) and an external ALU.
module neander_control
    import neander_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF   // operand byte is an address, keep equal to DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic [2:0]            alu_sel,
    output logic [DATA_WIDTH-1:0] ac_out,
    output logic [DATA_WIDTH-1:0] rdm_out,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [1:0]            nz_in,
    output logic                  halted
);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_rdm;
    logic [DATA_WIDTH-1:0] r_ri;
    logic [DATA_WIDTH-1:0] r_ac;
    logic [1:0]            r_nz;

    // Two decoders: index 0 looks at the byte arriving from RAM in DECODE,
    // index 1 at the latched instruction for the later states.
    logic [3:0] w_dec_op [2];
    logic [1:0] w_is_jump;
    logic [1:0] w_is_alu;
    logic [1:0] w_needs_operand;
    logic [1:0] w_is_store;
    logic [1:0] w_is_halt;
    logic [2:0] w_alu_sel [2];
    logic       w_taken;
    logic       w_unused;

    assign w_dec_op[0] = mem_rdata[DATA_WIDTH-1 -: 4];
    assign w_dec_op[1] = r_ri[DATA_WIDTH-1 -: 4];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            neander_decode u_decode (
                .opcode        (w_dec_op[gi]),
                .is_jump       (w_is_jump[gi]),
                .is_alu        (w_is_alu[gi]),
                .needs_operand (w_needs_operand[gi]),
                .is_store      (w_is_store[gi]),
                .is_halt       (w_is_halt[gi]),
                .alu_sel       (w_alu_sel[gi])
            );
        end
    endgenerate

    // Decoder outputs and RI low nibble that this datapath never consumes
    assign w_unused = ^{w_is_jump[0], w_is_store[0], w_alu_sel[0],
                        w_needs_operand[1], w_is_alu[1], w_is_halt[1],
                        r_ri[DATA_WIDTH-5:0]};

    // Branch decision uses the NZ register, never the live AC
    assign w_taken = jump_taken(w_dec_op[1], r_nz);

    assign alu_sel   = w_alu_sel[1];
    assign ac_out    = r_ac;
    assign rdm_out   = r_rdm;
    assign mem_wdata = r_ac;
    assign halted    = (r_state == ST_HALT);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, memory address and write-enable; write is gated by reset
    // so an aborted STORE never reaches the RAM
    always_comb begin
        w_state_next = r_state;
        mem_addr     = r_pc;
        mem_we       = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_is_halt[0]) begin
                    w_state_next = ST_HALT;
                end else if (w_needs_operand[0]) begin
                    w_state_next = ST_OPER;
                end else if (w_is_alu[0]) begin
                    w_state_next = ST_EXEC;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_OPER: begin
                w_state_next = ST_OPER_W;
            end
            ST_OPER_W: begin
                if (w_is_jump[1]) begin
                    w_state_next = ST_FETCH;
                end else if (w_is_store[1]) begin
                    w_state_next = ST_STORE;
                end else begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                mem_addr     = r_rem;
                w_state_next = ST_LDRDM;
            end
            ST_LDRDM: begin
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_next = ST_FETCH;
            end
            ST_STORE: begin
                mem_addr     = r_rem;
                mem_we       = reset_n;
                w_state_next = ST_FETCH;
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    // Register file updates, each tied to the state that owns it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc  <= '0;
            r_rem <= '0;
            r_rdm <= '0;
            r_ri  <= '0;
            r_ac  <= '0;
            r_nz  <= 2'b01;
        end else begin
            case (r_state)
                ST_DECODE: begin
                    r_ri <= mem_rdata;
                    r_pc <= r_pc + 1'b1;
                end
                ST_OPER_W: begin
                    if (w_is_jump[1]) begin
                        if (w_taken) begin
                            r_pc <= mem_rdata;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end else begin
                        r_rem <= mem_rdata;
                        r_pc  <= r_pc + 1'b1;
                    end
                end
                ST_LDRDM: begin
                    r_rdm <= mem_rdata;
                end
                ST_EXEC: begin
                    r_ac <= alu_result;
                    r_nz <= nz_in;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neander_control.sv
// Bench for neander_control: small behavioural ALU, 256x8 sync RAM with a
// write log, and short programs checked for final state, cycle counts and writes.
module tb_neander_control;
    import neander_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [2:0] alu_sel;
    logic [7:0] ac_out;
    logic [7:0] rdm_out;
    logic [7:0] alu_result;
    logic [1:0] nz_in;
    logic       halted;

    int n_cmp = 0;
    int n_bad = 0;

    // RAM model controls
    logic [7:0]  ram [256];
    logic        tb_clr = 1'b0;
    logic        tb_ld = 1'b0;
    logic [7:0]  tb_ld_addr = 8'h00;
    logic [7:0]  tb_ld_data = 8'h00;
    logic [15:0] q_exp [$];
    logic [15:0] q_wr [$];

    // ALU flag override, used to show the branch follows the NZ register
    logic       force_nz_en = 1'b0;
    logic [1:0] force_nz_val = 2'b00;

    neander_control #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .alu_sel    (alu_sel),
        .ac_out     (ac_out),
        .rdm_out    (rdm_out),
        .alu_result (alu_result),
        .nz_in      (nz_in),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: ADD/AND/OR on (AC,RDM), NOT on AC, PASS forwards RDM
    always_comb begin
        alu_result = rdm_out;
        case (alu_sel)
            3'b000:  alu_result = ac_out + rdm_out;
            3'b001:  alu_result = ac_out & rdm_out;
            3'b010:  alu_result = ac_out | rdm_out;
            3'b011:  alu_result = ~ac_out;
            default: alu_result = rdm_out;
        endcase
        nz_in = {alu_result[7], (alu_result == 8'h00)};
        if (force_nz_en) nz_in = force_nz_val;
    end

    // Synchronous RAM with bench-side clear/load and a log of every CPU write
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (tb_ld) begin
            ram[tb_ld_addr] <= tb_ld_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            q_wr.push_back({mem_addr, mem_wdata});
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic prog_begin();
        reset_n = 1'b0;
        tb_clr  = 1'b1;
        @(posedge clk); #1;
        tb_clr  = 1'b0;
        q_wr.delete();
        q_exp.delete();
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_ld      = 1'b1;
        tb_ld_addr = a;
        tb_ld_data = d;
        @(posedge clk); #1;
        tb_ld      = 1'b0;
    endtask

    task automatic prog_go();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic run_until_halt(input int budget, output int cyc);
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        prog_begin();
        poke(8'h00, 8'h20); poke(8'h01, 8'h80); poke(8'h80, 8'h5A);
        prog_go();
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_pc: got %h want 00", mem_addr); end
        n_cmp++; if (ac_out !== 8'h00) begin n_bad++; $display("FAIL reset_ac: got %h want 00", ac_out); end
        n_cmp++; if (dut.r_nz !== 2'b01) begin n_bad++; $display("FAIL reset_nz: got %b want 01", dut.r_nz); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        $display("test_reset: pc=%h ac=%h nz=%b", mem_addr, ac_out, dut.r_nz);
    endtask

    task automatic test_lda_add_sta();
        int cyc;
        logic [15:0] e, o;
        prog_begin();
        poke(8'h00, 8'h20); poke(8'h01, 8'h80);
        poke(8'h02, 8'h30); poke(8'h03, 8'h81);
        poke(8'h04, 8'h10); poke(8'h05, 8'h82);
        poke(8'h06, 8'hF0);
        poke(8'h80, 8'h05); poke(8'h81, 8'h07);
        q_exp.push_back({8'h82, 8'h0C});
        prog_go();
        run_until_halt(100, cyc);
        n_cmp++; if (cyc !== 21) begin n_bad++; $display("FAIL prog2_cycles: got %0d want 21", cyc); end
        n_cmp++; if (mem_addr !== 8'h07) begin n_bad++; $display("FAIL prog2_pc: got %h want 07", mem_addr); end
        n_cmp++; if (dut.r_nz !== 2'b00) begin n_bad++; $display("FAIL prog2_nz: got %b want 00", dut.r_nz); end
        n_cmp++; if (ram[8'h82] !== 8'h0C) begin n_bad++; $display("FAIL prog2_ram82: got %h want 0C", ram[8'h82]); end
        n_cmp++; if (q_wr.size() !== q_exp.size()) begin n_bad++; $display("FAIL prog2_nwrites: got %0d want %0d", q_wr.size(), q_exp.size()); end
        while (q_wr.size() > 0 && q_exp.size() > 0) begin
            o = q_wr.pop_front();
            e = q_exp.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL prog2_write: got %h want %h", o, e); end
        end
        $display("test_lda_add_sta: cycles=%0d pc=%h ac=%h", cyc, mem_addr, ac_out);
    endtask

    task automatic test_jz();
        int cyc;
        prog_begin();
        poke(8'h00, 8'h20); poke(8'h01, 8'h80);
        poke(8'h02, 8'hA0); poke(8'h03, 8'h10);
        poke(8'h04, 8'hF0);
        poke(8'h10, 8'h20); poke(8'h11, 8'h81);
        poke(8'h12, 8'hA0); poke(8'h13, 8'h20);
        poke(8'h14, 8'hF0);
        poke(8'h20, 8'hF0);
        poke(8'h81, 8'h03);
        prog_go();
        run_until_halt(100, cyc);
        n_cmp++; if (mem_addr !== 8'h15) begin n_bad++; $display("FAIL jz_pc: got %h want 15", mem_addr); end
        n_cmp++; if (cyc !== 24) begin n_bad++; $display("FAIL jz_cycles: got %0d want 24", cyc); end
        n_cmp++; if (ac_out !== 8'h03) begin n_bad++; $display("FAIL jz_ac: got %h want 03", ac_out); end
        $display("test_jz: cycles=%0d pc=%h", cyc, mem_addr);
    endtask

    task automatic test_jn();
        int cyc;
        for (int k = 0; k < 2; k++) begin
            prog_begin();
            poke(8'h00, 8'h20); poke(8'h01, 8'h80);
            poke(8'h02, 8'h90); poke(8'h03, 8'h30);
            poke(8'h04, 8'hF0); poke(8'h30, 8'hF0);
            poke(8'h80, 8'hF0);
            force_nz_en  = (k == 1);
            force_nz_val = 2'b00;
            prog_go();
            run_until_halt(100, cyc);
            force_nz_en = 1'b0;
            n_cmp++; if (ac_out !== 8'hF0) begin n_bad++; $display("FAIL jn_ac[%0d]: got %h want F0", k, ac_out); end
            n_cmp++; if (mem_addr !== ((k == 0) ? 8'h31 : 8'h05)) begin
                n_bad++; $display("FAIL jn_pc[%0d]: got %h want %h", k, mem_addr, (k == 0) ? 8'h31 : 8'h05);
            end
            $display("test_jn[%0d]: forced=%0d pc=%h", k, k, mem_addr);
        end
    endtask

    task automatic test_not_nop();
        int cyc;
        prog_begin();
        poke(8'h00, 8'h20); poke(8'h01, 8'h80);
        poke(8'h02, 8'h60); poke(8'h03, 8'hF0);
        poke(8'h80, 8'hFF);
        prog_go();
        run_until_halt(100, cyc);
        n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL not_cycles: got %0d want 12", cyc); end
        n_cmp++; if (ac_out !== 8'h00) begin n_bad++; $display("FAIL not_ac: got %h want 00", ac_out); end
        n_cmp++; if (dut.r_nz !== 2'b01) begin n_bad++; $display("FAIL not_nz: got %b want 01", dut.r_nz); end
        $display("test_not: cycles=%0d ac=%h", cyc, ac_out);
        for (int k = 0; k < 2; k++) begin
            prog_begin();
            poke(8'h00, (k == 0) ? 8'h7C : 8'h00);
            poke(8'h01, 8'hF0);
            prog_go();
            run_until_halt(100, cyc);
            n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL nop_cycles[%0d]: got %0d want 4", k, cyc); end
            n_cmp++; if (mem_addr !== 8'h02) begin n_bad++; $display("FAIL nop_pc[%0d]: got %h want 02", k, mem_addr); end
            n_cmp++; if (dut.r_nz !== 2'b01) begin n_bad++; $display("FAIL nop_nz[%0d]: got %b want 01", k, dut.r_nz); end
            $display("test_nop[%0d]: cycles=%0d pc=%h", k, cyc, mem_addr);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        prog_begin();
        poke(8'h00, 8'h80); poke(8'h01, 8'hFE);
        poke(8'hFE, 8'h80); poke(8'hFF, 8'h05);
        poke(8'h05, 8'hF0);
        prog_go();
        run_until_halt(100, cyc);
        n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL jmpff_cycles: got %0d want 10", cyc); end
        n_cmp++; if (mem_addr !== 8'h06) begin n_bad++; $display("FAIL jmpff_pc: got %h want 06", mem_addr); end
        $display("test_wrap jmp: cycles=%0d pc=%h", cyc, mem_addr);
        prog_begin();
        poke(8'h00, 8'h80); poke(8'h01, 8'hFE);
        poke(8'hFE, 8'h90); poke(8'hFF, 8'h40);
        prog_go();
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (dut.r_state !== ST_FETCH) begin n_bad++; $display("FAIL wrap_state: got %0d want FETCH", dut.r_state); end
        n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL wrap_pc: got %h want 00", mem_addr); end
        $display("test_wrap jn: pc=%h", mem_addr);
    endtask

    task automatic test_reset_in_store();
        prog_begin();
        poke(8'h00, 8'h20); poke(8'h01, 8'h80);
        poke(8'h02, 8'h10); poke(8'h03, 8'h90);
        poke(8'h04, 8'hF0);
        poke(8'h80, 8'hAA);
        prog_go();
        repeat (11) @(posedge clk);
        #1;
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL store_we_pre: got %b want 1", mem_we); end
        n_cmp++; if (mem_addr !== 8'h90) begin n_bad++; $display("FAIL store_addr: got %h want 90", mem_addr); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL store_we_rst: got %b want 0", mem_we); end
        @(posedge clk); #1;
        n_cmp++; if (ram[8'h90] !== 8'h00) begin n_bad++; $display("FAIL store_ram90: got %h want 00", ram[8'h90]); end
        n_cmp++; if (q_wr.size() !== 0) begin n_bad++; $display("FAIL store_nwrites: got %0d want 0", q_wr.size()); end
        n_cmp++; if (dut.r_state !== ST_FETCH) begin n_bad++; $display("FAIL store_state: got %0d want FETCH", dut.r_state); end
        n_cmp++; if (ac_out !== 8'h00) begin n_bad++; $display("FAIL store_ac: got %h want 00", ac_out); end
        n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL store_pc: got %h want 00", mem_addr); end
        $display("test_reset_in_store: we=%b ram90=%h", mem_we, ram[8'h90]);
    endtask

    initial begin
        test_reset();
        test_lda_add_sta();
        test_jz();
        test_jn();
        test_not_nop();
        test_wrap();
        test_reset_in_store();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
